// File: rtl/pixrep_pkg.sv
// Shared definitions for the pixel replication engine: FSM states, scale codes
// and the scale-code to shift decode.
package pixrep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SCALE_1X   = 2'd0;
  localparam logic [1:0] SCALE_2X   = 2'd1;
  localparam logic [1:0] SCALE_4X   = 2'd2;
  localparam logic [1:0] SCALE_RSVD = 2'd3;

  // The reserved code falls back to 1x.
  function automatic logic [1:0] scale_shift(input logic [1:0] sel);
    case (sel)
      SCALE_1X, SCALE_RSVD: return 2'd0;
      SCALE_2X:             return 2'd1;
      SCALE_4X:             return 2'd2;
      default:              return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pixrep_coord_counter.sv
// Output-frame x/y walker with run-time wrap at (W<<shift)-1 / (H<<shift)-1;
// also supplies the last-pixel flag and the linear output address.
module pixrep_coord_counter #(
  parameter int IMG_WIDTH_IN  = 160,
  parameter int IMG_HEIGHT_IN = 120,
  parameter int X_W           = 10,
  parameter int Y_W           = 9,
  parameter int A_W           = 19
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  input  logic [1:0]     shift,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last,
  output logic [A_W-1:0] lin_addr
);

  logic [X_W-1:0] x_last;
  logic [Y_W-1:0] y_last;
  logic [A_W-1:0] row_base;

  assign x_last = X_W'((IMG_WIDTH_IN << shift) - 1);
  assign y_last = Y_W'((IMG_HEIGHT_IN << shift) - 1);
  assign last   = (x == x_last) && (y == y_last);

  // y*W_OUT folded into a constant multiply followed by the scale shift.
  assign row_base = A_W'(y) * A_W'(IMG_WIDTH_IN);
  assign lin_addr = (row_base << shift) + A_W'(x);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == x_last) begin
        x <= '0;
        y <= (y == y_last) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_replication_engine.sv
// Nearest-neighbour frame upscaler (1x/2x/4x), one replicated pixel per clock.
// Optional horizontal mirror on the read side when PIXREP_MIRROR_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for START; counters held at zero
// ST_RUN   | one read per cycle while x/y walk the output frame
// ST_FLUSH | last read's data lands, last write issued
// ST_DONE  | DONE pulse, START ignored
module pixel_replication_engine
  import pixrep_pkg::*;
#(
  parameter int IMG_WIDTH_IN  = 160,
  parameter int IMG_HEIGHT_IN = 120,
  parameter int R_ADDR_W      = 15,
  parameter int W_ADDR_W      = 19
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [1:0]          SCALE_SEL,
`ifdef PIXREP_MIRROR_EN
  input  logic                MIRROR_X,
`endif
  output logic [R_ADDR_W-1:0] R_ADDR,
  input  logic [7:0]          PIXEL_IN,
  output logic [W_ADDR_W-1:0] W_ADDR,
  output logic [7:0]          W_DATA,
  output logic                W_EN,
  output logic                BUSY,
  output logic                DONE
);

  localparam int X_W = $clog2(IMG_WIDTH_IN * 4);
  localparam int Y_W = $clog2(IMG_HEIGHT_IN * 4);

  state_e              state;
  logic [1:0]          shift;
  logic                run;
  logic                clear;
  logic                last;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [W_ADDR_W-1:0] lin_addr;
  logic [R_ADDR_W-1:0] src_x;
  logic [R_ADDR_W-1:0] src_y;
  logic [R_ADDR_W-1:0] col;

  assign run   = (state == ST_RUN);
  assign clear = (state == ST_IDLE) && START;

  pixrep_coord_counter #(
    .IMG_WIDTH_IN (IMG_WIDTH_IN),
    .IMG_HEIGHT_IN(IMG_HEIGHT_IN),
    .X_W          (X_W),
    .Y_W          (Y_W),
    .A_W          (W_ADDR_W)
  ) u_coord (
    .clk     (CLK),
    .reset   (RESET),
    .clear   (clear),
    .advance (run),
    .shift   (shift),
    .x       (x),
    .y       (y),
    .last    (last),
    .lin_addr(lin_addr)
  );

  assign src_x = R_ADDR_W'(x >> shift);
  assign src_y = R_ADDR_W'(y >> shift);

`ifdef PIXREP_MIRROR_EN
  logic mirror;
  assign col = mirror ? (R_ADDR_W'(IMG_WIDTH_IN - 1) - src_x) : src_x;
`else
  assign col = src_x;
`endif

  assign R_ADDR = src_y * R_ADDR_W'(IMG_WIDTH_IN) + col;

  // Read data arrives in the write cycle, so it passes straight through.
  assign W_DATA = W_EN ? PIXEL_IN : 8'd0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      shift  <= 2'd0;
      W_ADDR <= '0;
      W_EN   <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
`ifdef PIXREP_MIRROR_EN
      mirror <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      W_EN <= run;
      if (run) W_ADDR <= lin_addr;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state <= ST_RUN;
            shift <= scale_shift(SCALE_SEL);
            BUSY  <= 1'b1;
`ifdef PIXREP_MIRROR_EN
            mirror <= MIRROR_X;
`endif
          end
        end
        ST_RUN: begin
          if (last) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          state <= ST_DONE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
